// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. Takes one load/store at a
//   time over a valid/ready handshake, performs byte/halfword/word accesses
//   with RISC-V sub-word semantics on a word-organised array, and returns
//   read data plus an error flag after WAIT_STATES extra cycles.
//
//   Optional feature: define DMEM_BOUNDS_CHECK_EN to flag any address at or
//   above 4*DEPTH_WORDS as an error. Without it, addresses wrap modulo the
//   array size and only funct/alignment errors are reported.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_STATES  extra cycles between acceptance and response (0..7)
// Ports
//   i_Clock, i_Reset_n          clock, async active-low reset
//   i_ReqValid / o_ReqReady     request handshake (ready only when idle)
//   i_ReqWrite, i_ReqFunct      store flag, RISC-V funct3
//   i_ReqAddress                byte address
//   i_ReqWriteData              right-aligned store data
//   o_RespValid / i_RespReady   response handshake
//   o_RespReadData, o_RespError load result (0 for stores/errors), error
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [2:0]  i_ReqFunct,
  input  logic [31:0] i_ReqAddress,
  input  logic [31:0] i_ReqWriteData,
  output logic        o_RespValid,
  input  logic        i_RespReady,
  output logic [31:0] o_RespReadData,
  output logic        o_RespError
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit ZeroWait = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, nextState;
  logic [2:0]  waitCnt;
  logic        accept, enterResp;

  logic        latWrite;
  logic [2:0]  latFunct;
  logic [31:0] latAddress, latWriteData;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- FSM ----------------
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = ZeroWait ? RESP : WAIT;
      WAIT: if (waitCnt == 3'd1) nextState = RESP;
      RESP: if (i_RespReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    o_ReqReady  = (state == IDLE);
    o_RespValid = (state == RESP);
    accept      = i_ReqValid && (state == IDLE);
    // The access fires exactly once, on the edge that enters RESP.
    enterResp   = (accept && ZeroWait) || (state == WAIT && waitCnt == 3'd1);
  end

  // ---------------- request latch / wait counter ----------------
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      latWrite     <= 1'b0;
      latFunct     <= 3'd0;
      latAddress   <= 32'd0;
      latWriteData <= 32'd0;
      waitCnt      <= 3'd0;
    end else begin
      if (accept) begin
        latWrite     <= i_ReqWrite;
        latFunct     <= i_ReqFunct;
        latAddress   <= i_ReqAddress;
        latWriteData <= i_ReqWriteData;
        waitCnt      <= 3'(WAIT_STATES);
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 3'd1;
      end
    end
  end

  // With zero wait states the access happens on the accepting edge, before
  // the latch holds the request, so decode straight from the inputs in IDLE.
  logic        srcWrite;
  logic [2:0]  srcFunct;
  logic [31:0] srcAddress, srcWriteData;

  always_comb begin
    srcWrite     = (state == IDLE) ? i_ReqWrite     : latWrite;
    srcFunct     = (state == IDLE) ? i_ReqFunct     : latFunct;
    srcAddress   = (state == IDLE) ? i_ReqAddress   : latAddress;
    srcWriteData = (state == IDLE) ? i_ReqWriteData : latWriteData;
  end

  // ---------------- access decode ----------------
  logic [1:0]    size;
  logic          functBad, alignBad, rangeBad, accessErr;
  logic [AW-1:0] wordIdx;
  logic [31:0]   rdWord, loadData, wrData;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [3:0]    wrBe;
  logic          memWe;

  always_comb begin
    size     = srcFunct[1:0];
    functBad = srcWrite ? (srcFunct > 3'b010)
                        : (srcFunct == 3'b011 || srcFunct[2:1] == 2'b11);
    alignBad = (size == 2'b01 && srcAddress[0]) ||
               (size == 2'b10 && srcAddress[1:0] != 2'b00);
`ifdef DMEM_BOUNDS_CHECK_EN
    rangeBad = |(srcAddress >> (AW + 2));
`else
    rangeBad = 1'b0;
`endif
    accessErr = functBad || alignBad || rangeBad;

    // Truncation drops the upper address bits, which gives the wrap.
    wordIdx = AW'(srcAddress >> 2);
    rdWord  = mem[wordIdx];
    byteSel = 8'(rdWord >> {srcAddress[1:0], 3'b000});
    halfSel = 16'(rdWord >> {srcAddress[1], 4'b0000});

    case (srcFunct)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b010:  loadData = rdWord;
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = 32'd0;
    endcase

    // Replicate the store data across lanes; byte enables pick the target.
    case (size)
      2'b00:   wrData = {4{srcWriteData[7:0]}};
      2'b01:   wrData = {2{srcWriteData[15:0]}};
      default: wrData = srcWriteData;
    endcase
    case (size)
      2'b00:   wrBe = 4'b0001 << srcAddress[1:0];
      2'b01:   wrBe = srcAddress[1] ? 4'b1100 : 4'b0011;
      2'b10:   wrBe = 4'b1111;
      default: wrBe = 4'b0000;
    endcase

    memWe = enterResp && srcWrite && !accessErr;
  end

  // Storage is intentionally not reset.
  always_ff @(posedge i_Clock) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++)
        if (wrBe[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
    end
  end

  // ---------------- response registers ----------------
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_RespReadData <= 32'd0;
      o_RespError    <= 1'b0;
    end else if (enterResp) begin
      o_RespReadData <= (srcWrite || accessErr) ? 32'd0 : loadData;
      o_RespError    <= accessErr;
    end else if (state == RESP && i_RespReady) begin
      o_RespReadData <= 32'd0;
      o_RespError    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;
  localparam int BYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid, reqReady, reqWrite;
  logic [2:0]  reqFunct;
  logic [31:0] reqAddress, reqWriteData;
  logic        respValid, respReady, respError;
  logic [31:0] respReadData;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .i_Clock(clk), .i_Reset_n(rstN),
    .i_ReqValid(reqValid), .o_ReqReady(reqReady),
    .i_ReqWrite(reqWrite), .i_ReqFunct(reqFunct),
    .i_ReqAddress(reqAddress), .i_ReqWriteData(reqWriteData),
    .o_RespValid(respValid), .i_RespReady(respReady),
    .o_RespReadData(respReadData), .o_RespError(respError)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] d; logic e; } exp_t;
  exp_t sb[$];

  // Reference memory as a flat byte array (little-endian).
  logic [7:0] refMem [BYTES];
  bit randReady = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: decides error, updates memory for good stores,
  // returns extended load data.
  function automatic void model(input bit wr, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int unsigned base, nbytes, size;
    logic [31:0] v;
    rd = 32'd0;
    size = f[1:0];
    if (wr) er = (f > 3'b010);
    else    er = (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
    if (size == 1 && a % 2 != 0) er = 1;
    if (size == 2 && a % 4 != 0) er = 1;
`ifdef DMEM_BOUNDS_CHECK_EN
    if (a >= BYTES) er = 1;
`endif
    if (er) return;
    base   = a % BYTES;
    nbytes = 1 << size;
    if (wr) begin
      for (int i = 0; i < nbytes; i++) refMem[base + i] = 8'(wd >> (8 * i));
    end else begin
      v = 32'd0;
      for (int i = 0; i < nbytes; i++) v |= {24'd0, refMem[base + i]} << (8 * i);
      if (!f[2] && size != 2 && v[8 * nbytes - 1]) v |= 32'hFFFF_FFFF << (8 * nbytes);
      rd = v;
    end
  endfunction

  // Monitor: pops the scoreboard on every retiring response.
  always @(negedge clk) begin
    exp_t e;
    if (rstN && respValid && respReady) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got data %h err %b with empty scoreboard", respReadData, respError);
      end else begin
        e = sb.pop_front();
        chk("resp_data", respReadData, e.d);
        chk("resp_err", 32'(respError), 32'(e.e));
      end
    end
  end

  // Random response backpressure, changed away from the sampling edge.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (randReady) respReady = 1'($urandom_range(0, 1));
    end
  end

  // Issue one request; returns once its response is presented.
  task automatic doReq(input bit wr, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input bit lit,
                       input logic [31:0] litD, input bit litE);
    logic [31:0] md; bit me; exp_t e; int n, lat;
    model(wr, f, a, wd, md, me);
    e.d = lit ? litD : md;
    e.e = lit ? litE : me;
    sb.push_back(e);
    @(negedge clk);
    reqValid = 1; reqWrite = wr; reqFunct = f; reqAddress = a; reqWriteData = wd;
    n = 0;
    while (!reqReady && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL req_timeout: got ready %b expected 1 within 200 cycles", reqReady);
      reqValid = 0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk); #1;
    reqValid = 0;
    lat = 0;
    while (!respValid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(WS));
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() > 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] md; bit me; int n;
    logic [2:0] f; logic [31:0] a; bit wr;
    rstN = 0; reqValid = 0; reqWrite = 0; reqFunct = 0;
    reqAddress = 0; reqWriteData = 0; respReady = 1;
    repeat (3) @(negedge clk);
    chk("rst_reqReady", 32'(reqReady), 32'd1);
    chk("rst_respValid", 32'(respValid), 32'd0);
    chk("rst_data", respReadData, 32'd0);
    chk("rst_err", 32'(respError), 32'd0);
    @(negedge clk); rstN = 1;

    // Fill the whole array so every later load has defined data.
    for (int w = 0; w < DEPTH; w++) doReq(1, 3'b010, 32'(w * 4), $urandom, 0, 0, 0);

    // Directed sequence
    doReq(1, 3'b010, 32'h10, 32'h8000_00F1, 1, 32'h0, 0);
    doReq(0, 3'b010, 32'h10, 32'h0, 1, 32'h8000_00F1, 0);
    doReq(0, 3'b000, 32'h10, 32'h0, 1, 32'hFFFF_FFF1, 0);
    doReq(0, 3'b100, 32'h10, 32'h0, 1, 32'h0000_00F1, 0);
    doReq(0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFF_8000, 0);
    doReq(0, 3'b101, 32'h12, 32'h0, 1, 32'h0000_8000, 0);
    doReq(1, 3'b000, 32'h11, 32'hFFFF_FFAB, 1, 32'h0, 0);
    doReq(0, 3'b010, 32'h10, 32'h0, 1, 32'h8000_ABF1, 0);
    doReq(0, 3'b001, 32'h13, 32'h0, 1, 32'h0, 1);
    doReq(1, 3'b010, 32'h12, 32'h1234_5678, 1, 32'h0, 1);
    doReq(0, 3'b010, 32'h10, 32'h0, 1, 32'h8000_ABF1, 0);
    doReq(0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1);
    doReq(1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1);
`ifdef DMEM_BOUNDS_CHECK_EN
    doReq(0, 3'b010, 32'(BYTES + 'h10), 32'h0, 1, 32'h0, 1);
`else
    doReq(0, 3'b010, 32'(BYTES + 'h10), 32'h0, 1, 32'h8000_ABF1, 0);
`endif

    // Backpressure: hold the response while a second request waits.
    waitDrain();
    respReady = 0;
    doReq(0, 3'b010, 32'h10, 32'h0, 1, 32'h8000_ABF1, 0);
    begin
      exp_t e2;
      model(0, 3'b010, 32'h14, 32'h0, md, me);
      e2.d = md; e2.e = me;
      sb.push_back(e2);
    end
    @(negedge clk);
    reqValid = 1; reqWrite = 0; reqFunct = 3'b010; reqAddress = 32'h14; reqWriteData = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(respValid), 32'd1);
      chk("bp_data", respReadData, 32'h8000_ABF1);
      chk("bp_err", 32'(respError), 32'd0);
      chk("bp_reqReady", 32'(reqReady), 32'd0);
    end
    @(posedge clk); #2 respReady = 1;
    n = 0;
    while (!reqReady && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    reqValid = 0;
    chk("bp_accepted", 32'(reqReady), 32'd0);

    // Reset during WAIT of a store: store must be discarded.
    waitDrain();
    @(negedge clk);
    reqValid = 1; reqWrite = 1; reqFunct = 3'b010; reqAddress = 32'h20; reqWriteData = 32'hDEAD_BEEF;
    n = 0;
    while (!reqReady && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    reqValid = 0;
    @(negedge clk); rstN = 0; #1;
    chk("rstmid_reqReady", 32'(reqReady), 32'd1);
    chk("rstmid_respValid", 32'(respValid), 32'd0);
    chk("rstmid_data", respReadData, 32'd0);
    chk("rstmid_err", 32'(respError), 32'd0);
    @(negedge clk); rstN = 1;
    doReq(0, 3'b010, 32'h20, 32'h0, 0, 0, 0);

    // Random traffic with random response backpressure.
    randReady = 1;
    for (int k = 0; k < 150; k++) begin
      wr = ($urandom_range(0, 2) == 0);
      f  = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 3) != 0)
        a = a & ~32'((f[1:0] == 2'b10) ? 3 : (f[1:0] == 2'b01) ? 1 : 0);
      if ($urandom_range(0, 7) == 0) a = a + 32'(BYTES * $urandom_range(1, 3));
      doReq(wr, f, a, $urandom, 0, 0, 0);
    end
    randReady = 0;
    @(posedge clk); #3 respReady = 1;
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
